// File: rtl/mips_pkg.sv
// Constants shared by the MIPS pipeline front end: bubble encoding, fetch-state
// encodings and the opcodes the hazard unit decodes.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_STALL = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [5:0] RTYPE_OP = 6'b000000;
    localparam logic [5:0] J_OP     = 6'b000010;
    localparam logic [5:0] BEQ_OP   = 6'b000100;
    localparam logic [5:0] BNE_OP   = 6'b000101;
    localparam logic [5:0] LW_OP    = 6'b100011;
    localparam logic [5:0] SW_OP    = 6'b101011;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the fetch stall/flush statistics.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, stall and
// branch-redirect handling, plus saturating stall/flush statistics.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             holdPC,
    input  logic             holdIF_ID,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      IF_ID_instruction,
    output logic [31:0]      IF_ID_pc4,
    output logic             IF_ID_valid,
    output logic [1:0]       fetch_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    import mips_pkg::*;

    logic [31:0]  pc_q;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_pc;
    fetch_state_e state_q;
    logic         stall_inc;
    logic         flush_inc;

    // One adder feeds both the next PC and the stored IF_ID_pc4.
    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = branch_target & ~32'h3;
    assign imem_addr   = pc_q;
    assign fetch_state = state_q;

    // A branch discards any simultaneous hold, so it must not count as a stall.
    assign stall_inc = ~branch_taken & (holdPC | holdIF_ID);
    assign flush_inc = branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q              <= RESET_PC;
            IF_ID_instruction <= NOP_INSTR;
            IF_ID_pc4         <= 32'd0;
            IF_ID_valid       <= 1'b0;
            state_q           <= FETCH_RUN;
        end else if (branch_taken) begin
            pc_q              <= redirect_pc;
            IF_ID_instruction <= NOP_INSTR;
            IF_ID_pc4         <= 32'd0;
            IF_ID_valid       <= 1'b0;
            state_q           <= FETCH_FLUSH;
        end else if (holdIF_ID) begin
            // Full freeze even without holdPC so the instruction in IF/ID is kept.
            state_q <= FETCH_STALL;
        end else if (holdPC) begin
            IF_ID_instruction <= NOP_INSTR;
            IF_ID_valid       <= 1'b0;
            state_q           <= FETCH_STALL;
        end else begin
            pc_q              <= pc_plus4;
            IF_ID_instruction <= imem_rdata;
            IF_ID_pc4         <= pc_plus4;
            IF_ID_valid       <= 1'b1;
            state_q           <= FETCH_RUN;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(stall_cycles)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush_inc),
        .count(flush_count)
    );

endmodule
